// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// it word by word into instruction memory while holding the CPU in reset.
module imem_boot_loader #(
    parameter int ROM_SIZE   = 256,
    parameter bit SAFE_START = 1'b1,
    parameter int AW         = $clog2(ROM_SIZE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_boot_req,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    output logic          o_we,
    output logic [AW-1:0] o_waddr,
    output logic [31:0]   o_wdata,
    output logic          o_cpu_hold,
    output logic          o_error,
    output logic [15:0]   o_words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_RUN   = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(ROM_SIZE) - 17'(SAFE_START);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    state_t        state_q;
    logic [7:0]    len_lo_q;
    logic [15:0]   len_q;
    logic [31:0]   asm_q;
    logic [7:0]    csum_q;
    logic [1:0]    bcnt_q;

    logic          xfer_s;
    logic [15:0]   len_s;
    logic          len_bad_s;
    logic [31:0]   word_s;
    logic [AW-1:0] waddr_next_s;
    logic          last_word_s;

    assign xfer_s       = i_byte_valid & o_byte_ready;
    assign len_s        = {i_byte_data, len_lo_q};
    assign len_bad_s    = (len_s == 16'd0) || ({1'b0, len_s} > MAX_LEN);
    // Bytes arrive least-significant first, so each new byte enters at the top.
    assign word_s       = {i_byte_data, asm_q[31:8]};
    assign waddr_next_s = AW'(32'(SAFE_START) + 32'(o_words_loaded));
    assign last_word_s  = ((o_words_loaded + 16'd1) == len_q);

    // Loader FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            len_lo_q       <= 8'd0;
            len_q          <= 16'd0;
            asm_q          <= 32'd0;
            csum_q         <= 8'd0;
            bcnt_q         <= 2'd0;
            o_byte_ready   <= 1'b0;
            o_we           <= 1'b0;
            o_waddr        <= {AW{1'b0}};
            o_wdata        <= 32'd0;
            o_cpu_hold     <= 1'b1;
            o_error        <= 1'b0;
            o_words_loaded <= 16'd0;
        end else begin
            o_we <= 1'b0;
            case (state_q)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (i_boot_req) begin
                        state_q        <= S_LEN0;
                        o_byte_ready   <= 1'b1;
                        o_error        <= 1'b0;
                        o_words_loaded <= 16'd0;
                        o_cpu_hold     <= 1'b1;
                        csum_q         <= 8'd0;
                        bcnt_q         <= 2'd0;
                        asm_q          <= 32'd0;
                        if (SAFE_START) begin
                            o_we    <= 1'b1;
                            o_waddr <= {AW{1'b0}};
                            o_wdata <= NOP_INSN;
                        end
                    end
                end
                S_LEN0: begin
                    if (xfer_s) begin
                        len_lo_q <= i_byte_data;
                        state_q  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer_s) begin
                        len_q <= len_s;
                        if (len_bad_s) begin
                            state_q      <= S_ERROR;
                            o_byte_ready <= 1'b0;
                            o_error      <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        asm_q  <= word_s;
                        csum_q <= csum_q ^ i_byte_data;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            o_we           <= 1'b1;
                            o_waddr        <= waddr_next_s;
                            o_wdata        <= word_s;
                            o_words_loaded <= o_words_loaded + 16'd1;
                            if (last_word_s) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer_s) begin
                        o_byte_ready <= 1'b0;
                        if (i_byte_data == csum_q) begin
                            state_q    <= S_RUN;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            o_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    o_byte_ready <= 1'b0;
                    o_cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule
